// File: rtl/key_step_ctrl.sv
// Step push-button conditioner: sync, debounce, press detect and STEP/RUN pulse generator.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat stepping in STEP mode.
module key_step_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        KeyN,
  input  logic        RunSel,
  output logic        StepPulse,
  output logic        KeyLevel,
  output logic        Running,
  output logic [15:0] StepCount
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_REL   = 2'd1,
    RUN_ACTIVE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] key_sync;
  logic [SYNC_STAGES-1:0] run_sync;
  logic                   key_s;
  logic                   run_s;

  logic [CNT_W-1:0]       db_cnt;
  logic                   key_level_p1;
  logic                   level_d_p1;
  logic                   press_p2;

  state_t                 state;
  logic [CNT_W-1:0]       rate_cnt;
  logic                   step_pulse;
  logic                   running;
  logic [15:0]            step_count;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_CYCLES = DEBOUNCE_CYCLES * 50;
  localparam int HOLD_W      = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              repeating;
`endif

  // Synchronizer stage: key is inverted so the chain resets to "released"
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      key_sync <= '0;
      run_sync <= '0;
    end else begin
      key_sync <= {key_sync[SYNC_STAGES-2:0], ~KeyN};
      run_sync <= {run_sync[SYNC_STAGES-2:0], RunSel};
    end
  end

  assign key_s = key_sync[SYNC_STAGES-1];
  assign run_s = run_sync[SYNC_STAGES-1];

  // Debounce stage: level accepted only after DEBOUNCE_CYCLES consecutive disagreements
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      db_cnt       <= '0;
      key_level_p1 <= 1'b0;
    end else if (key_s == key_level_p1) begin
      db_cnt       <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt       <= '0;
      key_level_p1 <= key_s;
    end else begin
      db_cnt       <= db_cnt + 1'b1;
    end
  end

  // Press-edge stage
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      level_d_p1 <= 1'b0;
      press_p2   <= 1'b0;
    end else begin
      level_d_p1 <= key_level_p1;
      press_p2   <= key_level_p1 & ~level_d_p1;
    end
  end

  // Step FSM stage: StepCount bumps on the same edge that raises StepPulse
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      rate_cnt   <= '0;
      step_pulse <= 1'b0;
      running    <= 1'b0;
      step_count <= '0;
`ifdef AUTO_REPEAT_EN
      hold_cnt   <= '0;
      repeating  <= 1'b0;
`endif
    end else begin
      step_pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
      if (state != WAIT_REL) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          if (press_p2) begin
            if (run_s) begin
              state    <= RUN_ACTIVE;
              running  <= 1'b1;
              rate_cnt <= '0;
            end else begin
              state      <= WAIT_REL;
              step_pulse <= 1'b1;
              step_count <= step_count + 16'd1;
            end
          end
        end

        WAIT_REL: begin
          if (!key_level_p1) begin
            state <= IDLE;
`ifdef AUTO_REPEAT_EN
          end else if (!run_s) begin
            if (!repeating) begin
              if (hold_cnt == HOLD_LAST) begin
                repeating <= 1'b1;
                rate_cnt  <= '0;
              end else begin
                hold_cnt  <= hold_cnt + 1'b1;
              end
            end else if (rate_cnt == RATE_LAST) begin
              rate_cnt   <= '0;
              step_pulse <= 1'b1;
              step_count <= step_count + 16'd1;
            end else begin
              rate_cnt   <= rate_cnt + 1'b1;
            end
`endif
          end
        end

        RUN_ACTIVE: begin
          // Mode switch has priority over a stop press, and both suppress a wrap pulse
          if (!run_s) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (press_p2) begin
            state   <= WAIT_REL;
            running <= 1'b0;
          end else if (rate_cnt == RATE_LAST) begin
            rate_cnt   <= '0;
            step_pulse <= 1'b1;
            step_count <= step_count + 16'd1;
          end else begin
            rate_cnt <= rate_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  assign StepPulse = step_pulse;
  assign KeyLevel  = key_level_p1;
  assign Running   = running;
  assign StepCount = step_count;

endmodule
